uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

    localparam int DATA_BITS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && valid[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte requesters with frame locking
// and a watchdog on the transmitter's busy handshake.
//
// state        | meaning
// IDLE         | waiting for an eligible requester, req_ready driven here only
// SEND         | tx_send high for this single cycle
// WAIT_BUSY    | waiting for tx_busy to rise, watchdog counting down
// WAIT_DONE    | transmitter busy, waiting for it to finish the character
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_BITS    = DATA_BITS_DEFAULT,
    parameter int BUSY_TIMEOUT = 16,
    parameter int IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ*DATA_BITS-1:0] req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]       tx_data,
    output logic                       tx_send,
    input  logic                       tx_busy,
    output logic [IDX_W-1:0]           grant_id,
    output logic                       frame_active,
    output logic                       err_timeout
);

    localparam int TO_W = $clog2(BUSY_TIMEOUT + 1);

    tx_state_e              state;
    logic [IDX_W-1:0]       rr_ptr;
    logic [TO_W-1:0]        to_cnt;
    logic                   last_q;

    logic [N_REQ-1:0]       arb_grant;
    logic [IDX_W-1:0]       arb_idx;
    logic                   arb_any;
    logic [N_REQ-1:0]       lock_grant;
    logic [IDX_W-1:0]       pick_idx;
    logic [DATA_BITS-1:0]   pick_data;
    logic                   accept;
    logic [IDX_W-1:0]       next_ptr;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // While a frame is locked only the owner may be granted, regardless of rr_ptr.
    always_comb begin
        lock_grant           = '0;
        lock_grant[grant_id] = req_valid[grant_id];
        pick_idx             = frame_active ? grant_id : arb_idx;
        pick_data            = req_data[int'(pick_idx)*DATA_BITS +: DATA_BITS];
        req_ready            = '0;
        if (reset_n && state == ST_IDLE && !tx_busy) begin
            if (frame_active)
                req_ready = lock_grant;
            else if (arb_any)
                req_ready = arb_grant;
        end
        accept = |req_ready;
    end

    assign next_ptr = IDX_W'(wrap_inc(int'(grant_id), N_REQ));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            to_cnt       <= '0;
            last_q       <= 1'b0;
            tx_data      <= '0;
            tx_send      <= 1'b0;
            grant_id     <= '0;
            frame_active <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            tx_send     <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        tx_data  <= pick_data;
                        grant_id <= pick_idx;
                        last_q   <= req_last[pick_idx];
                        if (!req_last[pick_idx])
                            frame_active <= 1'b1;
                        tx_send  <= 1'b1;
                        state    <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    // Loaded so the watchdog fires BUSY_TIMEOUT cycles after tx_send.
                    to_cnt <= TO_W'(BUSY_TIMEOUT - 2);
                    state  <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        to_cnt <= '0;
                        state  <= ST_WAIT_DONE;
                    end else if (to_cnt == '0) begin
                        err_timeout  <= 1'b1;
                        frame_active <= 1'b0;
                        rr_ptr       <= next_ptr;
                        state        <= ST_IDLE;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_q) begin
                            frame_active <= 1'b0;
                            rr_ptr       <= next_ptr;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small UART busy model and per-requester byte streams.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DB-1:0] req_data = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    req_ready;
    logic [DB-1:0]   tx_data;
    logic            tx_send;
    logic            tx_busy;
    logic [1:0]      grant_id;
    logic            frame_active;
    logic            err_timeout;

    logic uart_en = 1'b1;
    logic manual_busy = 1'b0;
    logic uart_busy;
    int   uart_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    assign tx_busy = uart_en ? uart_busy : manual_busy;

    uart_tx_arbiter #(.N_REQ(N), .DATA_BITS(DB), .BUSY_TIMEOUT(16)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .tx_data      (tx_data),
        .tx_send      (tx_send),
        .tx_busy      (tx_busy),
        .grant_id     (grant_id),
        .frame_active (frame_active),
        .err_timeout  (err_timeout)
    );

    // UART model: busy one cycle after tx_send, for five cycles.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            uart_busy <= 1'b0;
            uart_cnt  <= 0;
        end else if (uart_en && tx_send) begin
            uart_busy <= 1'b1;
            uart_cnt  <= 5;
        end else if (uart_cnt > 0) begin
            uart_cnt <= uart_cnt - 1;
            if (uart_cnt == 1) uart_busy <= 1'b0;
        end
    end

    logic [7:0] sent_data[$];
    int         sent_id[$];

    always @(negedge clock) begin
        if (reset_n && tx_send) begin
            sent_data.push_back(tx_data);
            sent_id.push_back(int'(grant_id));
        end
    end

    logic [7:0] s_data[N][8];
    logic       s_last[N][8];
    int         s_len[N];
    int         s_pos[N];

    int         cyc = 0;
    int         last_send_cyc = 0;
    int         last_err_cyc = 0;
    int         err_pulses = 0;
    int         bad_ready = 0;
    logic [N-1:0] last_ready = '0;

    task automatic push_byte(input int i, input logic [7:0] d, input logic l);
        s_data[i][s_len[i]] = d;
        s_last[i][s_len[i]] = l;
        s_len[i]++;
    endtask

    task automatic clear_streams();
        for (int i = 0; i < N; i++) begin
            s_len[i] = 0;
            s_pos[i] = 0;
        end
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            if (s_pos[i] < s_len[i]) begin
                req_valid[i]          = 1'b1;
                req_data[i*DB +: DB]  = s_data[i][s_pos[i]];
                req_last[i]           = s_last[i][s_pos[i]];
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DB +: DB]  = '0;
                req_last[i]           = 1'b0;
            end
        end
    endtask

    task automatic run_cycle();
        logic [N-1:0] acc;
        apply_inputs();
        @(negedge clock);
        acc        = req_valid & req_ready;
        last_ready = req_ready;
        if ($countones(req_ready) > 1 || (req_ready != '0 && tx_busy)) bad_ready++;
        if (tx_send) last_send_cyc = cyc;
        if (err_timeout) begin
            last_err_cyc = cyc;
            err_pulses++;
        end
        cyc++;
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++)
            if (acc[i]) s_pos[i]++;
    endtask

    task automatic run_until_sent(input int target, input int budget, input string tag);
        int n;
        n = 0;
        while (sent_data.size() < target && n < budget) begin
            run_cycle();
            n++;
        end
        n_cmp++;
        if (sent_data.size() != target) begin
            n_bad++;
            $display("FAIL %s sends: got %0d, expected %0d", tag, sent_data.size(), target);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        uart_en = 1'b1;
        manual_busy = 1'b0;
        clear_streams();
        apply_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        sent_data.delete();
        sent_id.delete();
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #12;
        clear_streams();
        push_byte(0, 8'h12, 1'b1);
        apply_inputs();
        #1;
        n_cmp++; if (tx_send !== 1'b0)      begin n_bad++; $display("FAIL reset_tx_send: got %b, expected 0", tx_send); end
        n_cmp++; if (tx_data !== 8'h00)     begin n_bad++; $display("FAIL reset_tx_data: got %02h, expected 00", tx_data); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready: got %b, expected 0000", req_ready); end
        n_cmp++; if (grant_id !== 2'd0)     begin n_bad++; $display("FAIL reset_grant_id: got %0d, expected 0", grant_id); end
        n_cmp++; if (frame_active !== 1'b0) begin n_bad++; $display("FAIL reset_frame_active: got %b, expected 0", frame_active); end
        n_cmp++; if (err_timeout !== 1'b0)  begin n_bad++; $display("FAIL reset_err_timeout: got %b, expected 0", err_timeout); end
    endtask

    task automatic test_single();
        do_reset();
        push_byte(0, 8'h55, 1'b1);
        run_until_sent(1, 50, "single");
        n_cmp++;
        if (sent_data.size() < 1 || sent_data[0] !== 8'h55 || sent_id[0] != 0) begin
            n_bad++; $display("FAIL single_byte: got sends=%0d, expected req 0 data 55", sent_data.size());
        end
        repeat (10) run_cycle();
        n_cmp++; if (frame_active !== 1'b0) begin n_bad++; $display("FAIL single_unlocked: got %b, expected 0", frame_active); end
        // rr_ptr should now be 1, so requester 1 wins over requester 0.
        push_byte(0, 8'h66, 1'b1);
        push_byte(1, 8'h77, 1'b1);
        run_until_sent(3, 100, "single_ptr");
        n_cmp++;
        if (sent_data.size() < 3 || sent_id[1] != 1 || sent_data[1] !== 8'h77 || sent_id[2] != 0 || sent_data[2] !== 8'h66) begin
            n_bad++; $display("FAIL single_rr_ptr: got sends=%0d, expected req1 77 then req0 66", sent_data.size());
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d[5];
        int         exp_i[5];
        logic [7:0] got_d;
        int         got_i;
        exp_d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h15};
        exp_i = '{0, 1, 2, 3, 0};
        do_reset();
        push_byte(0, 8'h11, 1'b1);
        push_byte(1, 8'h22, 1'b1);
        push_byte(2, 8'h33, 1'b1);
        push_byte(3, 8'h44, 1'b1);
        push_byte(0, 8'h15, 1'b1);
        run_until_sent(5, 200, "round_robin");
        for (int k = 0; k < 5; k++) begin
            got_d = (k < sent_data.size()) ? sent_data[k] : 8'hxx;
            got_i = (k < sent_id.size()) ? sent_id[k] : -1;
            n_cmp++;
            if (got_d !== exp_d[k] || got_i != exp_i[k]) begin
                n_bad++;
                $display("FAIL rr_order[%0d]: got req %0d data %02h, expected req %0d data %02h", k, got_i, got_d, exp_i[k], exp_d[k]);
            end
        end
    endtask

    task automatic test_frame();
        logic [7:0] exp_d[5];
        int         exp_i[5];
        logic [7:0] got_d;
        int         got_i;
        exp_d = '{8'hA5, 8'h5A, 8'h3C, 8'h77, 8'h78};
        exp_i = '{1, 1, 1, 2, 2};
        do_reset();
        push_byte(1, 8'hA5, 1'b0);
        push_byte(1, 8'h5A, 1'b0);
        push_byte(1, 8'h3C, 1'b1);
        push_byte(2, 8'h77, 1'b1);
        push_byte(2, 8'h78, 1'b1);
        run_until_sent(1, 50, "frame_first");
        n_cmp++; if (frame_active !== 1'b1) begin n_bad++; $display("FAIL frame_locked: got %b, expected 1", frame_active); end
        run_until_sent(5, 200, "frame");
        for (int k = 0; k < 5; k++) begin
            got_d = (k < sent_data.size()) ? sent_data[k] : 8'hxx;
            got_i = (k < sent_id.size()) ? sent_id[k] : -1;
            n_cmp++;
            if (got_d !== exp_d[k] || got_i != exp_i[k]) begin
                n_bad++;
                $display("FAIL frame_order[%0d]: got req %0d data %02h, expected req %0d data %02h", k, got_i, got_d, exp_i[k], exp_d[k]);
            end
        end
        repeat (10) run_cycle();
        n_cmp++; if (frame_active !== 1'b0) begin n_bad++; $display("FAIL frame_released: got %b, expected 0", frame_active); end
    endtask

    task automatic test_lock_hold();
        do_reset();
        push_byte(1, 8'hA1, 1'b0);
        run_until_sent(1, 50, "lock_first");
        repeat (10) run_cycle();
        push_byte(0, 8'hB0, 1'b1);
        repeat (20) run_cycle();
        n_cmp++; if (sent_data.size() != 1) begin n_bad++; $display("FAIL lock_hold_sends: got %0d, expected 1", sent_data.size()); end
        n_cmp++; if (frame_active !== 1'b1) begin n_bad++; $display("FAIL lock_hold_active: got %b, expected 1", frame_active); end
        n_cmp++; if (last_ready !== 4'b0000) begin n_bad++; $display("FAIL lock_hold_ready: got %b, expected 0000", last_ready); end
        push_byte(1, 8'hA2, 1'b1);
        run_until_sent(3, 100, "lock_resume");
        n_cmp++;
        if (sent_data.size() < 3 || sent_id[1] != 1 || sent_data[1] !== 8'hA2 || sent_id[2] != 0 || sent_data[2] !== 8'hB0) begin
            n_bad++; $display("FAIL lock_resume_order: got sends=%0d, expected req1 A2 then req0 B0", sent_data.size());
        end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        uart_en = 1'b0;
        manual_busy = 1'b0;
        err_pulses = 0;
        push_byte(3, 8'hE1, 1'b0);
        n = 0;
        while (err_pulses == 0 && n < 60) begin
            run_cycle();
            n++;
        end
        repeat (3) run_cycle();
        n_cmp++; if (err_pulses != 1) begin n_bad++; $display("FAIL timeout_pulses: got %0d, expected 1", err_pulses); end
        n_cmp++;
        if (last_err_cyc - last_send_cyc != 16) begin
            n_bad++; $display("FAIL timeout_delay: got %0d cycles, expected 16", last_err_cyc - last_send_cyc);
        end
        n_cmp++; if (frame_active !== 1'b0) begin n_bad++; $display("FAIL timeout_unlock: got %b, expected 0", frame_active); end
        n_cmp++;
        if (sent_id.size() < 1 || sent_id[0] != 3) begin
            n_bad++; $display("FAIL timeout_owner: got sends=%0d, expected req 3", sent_id.size());
        end
        uart_en = 1'b1;
        push_byte(0, 8'h42, 1'b1);
        push_byte(2, 8'h43, 1'b1);
        run_until_sent(2, 100, "timeout_recover");
        n_cmp++;
        if (sent_id.size() < 2 || sent_id[1] != 0 || sent_data[1] !== 8'h42) begin
            n_bad++; $display("FAIL timeout_recover_grant: got sends=%0d, expected req 0 data 42", sent_id.size());
        end
    endtask

    task automatic test_busy_idle();
        do_reset();
        uart_en = 1'b0;
        manual_busy = 1'b1;
        push_byte(2, 8'hC2, 1'b1);
        repeat (10) run_cycle();
        n_cmp++; if (sent_data.size() != 0) begin n_bad++; $display("FAIL busy_idle_sends: got %0d, expected 0", sent_data.size()); end
        n_cmp++; if (last_ready !== 4'b0000) begin n_bad++; $display("FAIL busy_idle_ready: got %b, expected 0000", last_ready); end
        uart_en = 1'b1;
        run_until_sent(1, 50, "busy_release");
        n_cmp++;
        if (sent_data.size() < 1 || sent_id[0] != 2 || sent_data[0] !== 8'hC2) begin
            n_bad++; $display("FAIL busy_release_byte: got sends=%0d, expected req 2 data C2", sent_data.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        push_byte(2, 8'h99, 1'b0);
        run_until_sent(1, 50, "reset_mid_first");
        repeat (3) run_cycle();
        #2;
        reset_n = 1'b0;
        clear_streams();
        apply_inputs();
        push_byte(1, 8'h5E, 1'b1);
        apply_inputs();
        #1;
        n_cmp++; if (tx_send !== 1'b0)      begin n_bad++; $display("FAIL midrst_tx_send: got %b, expected 0", tx_send); end
        n_cmp++; if (tx_data !== 8'h00)     begin n_bad++; $display("FAIL midrst_tx_data: got %02h, expected 00", tx_data); end
        n_cmp++; if (grant_id !== 2'd0)     begin n_bad++; $display("FAIL midrst_grant_id: got %0d, expected 0", grant_id); end
        n_cmp++; if (frame_active !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_active: got %b, expected 0", frame_active); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL midrst_req_ready: got %b, expected 0000", req_ready); end
        clear_streams();
        apply_inputs();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        repeat (20) run_cycle();
        n_cmp++; if (sent_data.size() != 1) begin n_bad++; $display("FAIL midrst_no_send: got %0d sends, expected 1", sent_data.size()); end
        push_byte(2, 8'h20, 1'b1);
        push_byte(0, 8'h10, 1'b1);
        run_until_sent(3, 100, "midrst_after");
        n_cmp++;
        if (sent_id.size() < 2 || sent_id[1] != 0 || sent_data[1] !== 8'h10) begin
            n_bad++; $display("FAIL midrst_first_grant: got sends=%0d, expected req 0 data 10", sent_id.size());
        end
    endtask

    task automatic test_protocol();
        n_cmp++;
        if (bad_ready != 0) begin
            n_bad++; $display("FAIL ready_protocol: got %0d bad cycles, expected 0", bad_ready);
        end
    endtask

    initial begin
        clear_streams();
        test_reset();
        test_single();
        test_round_robin();
        test_frame();
        test_lock_hold();
        test_timeout();
        test_busy_idle();
        test_reset_mid();
        test_protocol();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
